// File: rtl/branch_flag_unit_if.sv
// Bus bundle for branch_flag_unit: ALU result/flag inputs, branch request/response and trap control.
interface branch_flag_unit_if;
    logic        alu_valid;
    logic [31:0] alu_res;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_neg;
    logic        alu_ovf;
    logic        alu_update_carry;

    logic        br_valid;
    logic        br_ready;
    logic [2:0]  br_type;
    logic [31:0] br_target;
    logic [31:0] pc_plus4;

    logic        pc_valid;
    logic        take;
    logic [31:0] next_pc;
    logic        link_valid;
    logic [31:0] link_addr;

    logic [3:0]  flags;
    logic [31:0] res_q;
    logic        trap;
    logic        trap_ack;

    modport slave (
        input  alu_valid, alu_res, alu_carry, alu_zero, alu_neg, alu_ovf, alu_update_carry,
        input  br_valid, br_type, br_target, pc_plus4, trap_ack,
        output br_ready, pc_valid, take, next_pc, link_valid, link_addr, flags, res_q, trap
    );

    modport master (
        output alu_valid, alu_res, alu_carry, alu_zero, alu_neg, alu_ovf, alu_update_carry,
        output br_valid, br_type, br_target, pc_plus4, trap_ack,
        input  br_ready, pc_valid, take, next_pc, link_valid, link_addr, flags, res_q, trap
    );
endinterface

// File: rtl/branch_flag_unit.sv
// ALU flag registers plus a three-cycle (IDLE/EVAL/RESP) conditional branch resolver.
// Define BFU_OVF_TRAP_EN to enable the sticky overflow trap and its TRAP_VECTOR redirect.
module branch_flag_unit #(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              rst,
    branch_flag_unit_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EVAL = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic [2:0] BT_BR   = 3'b000;
    localparam logic [2:0] BT_BLTZ = 3'b001;
    localparam logic [2:0] BT_BZ   = 3'b010;
    localparam logic [2:0] BT_BNZ  = 3'b011;
    localparam logic [2:0] BT_BCY  = 3'b100;
    localparam logic [2:0] BT_BNC  = 3'b101;
    localparam logic [2:0] BT_BAL  = 3'b110;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_accept;
    logic        w_resolve;
    logic        w_retire;

    logic [2:0]  r_type;
    logic [31:0] r_target;
    logic [31:0] r_pc4;

    logic        r_c;
    logic        r_z;
    logic        r_n;
    logic        r_v;
    logic [31:0] r_res;

    logic        r_br_ready;
    logic        r_pc_valid;
    logic        r_take;
    logic [31:0] r_next_pc;
    logic        r_link_valid;
    logic [31:0] r_link_addr;

    logic        w_cond;
    logic        w_redirect;
    logic        w_take;
    logic        w_link;
    logic [31:0] w_pc;

    function automatic logic cond_met(input logic [2:0] t, input logic c, input logic z, input logic n);
        logic met;
        case (t)
            BT_BR:   met = 1'b1;
            BT_BLTZ: met = n;
            BT_BZ:   met = z;
            BT_BNZ:  met = ~z;
            BT_BCY:  met = c;
            BT_BNC:  met = ~c;
            BT_BAL:  met = 1'b1;
            default: met = 1'b0;
        endcase
        return met;
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and phase strobes
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_resolve    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.br_valid) begin
                    w_next_state = ST_EVAL;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_EVAL: begin
                w_next_state = ST_RESP;
                w_resolve    = 1'b1;
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
                w_retire     = 1'b1;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Latch the accepted branch request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_type   <= 3'b000;
            r_target <= 32'h0000_0000;
            r_pc4    <= 32'h0000_0000;
        end else if (w_accept) begin
            r_type   <= bus.br_type;
            r_target <= bus.br_target;
            r_pc4    <= bus.pc_plus4;
        end else begin
            r_type   <= r_type;
            r_target <= r_target;
            r_pc4    <= r_pc4;
        end
    end

    // Flag and result registers; C/V only move when the ALU asks for a carry update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res <= 32'h0000_0000;
            r_z   <= 1'b0;
            r_n   <= 1'b0;
            r_c   <= 1'b0;
            r_v   <= 1'b0;
        end else if (bus.alu_valid) begin
            r_res <= bus.alu_res;
            r_z   <= bus.alu_zero;
            r_n   <= bus.alu_neg;
            if (bus.alu_update_carry) begin
                r_c <= bus.alu_carry;
                r_v <= bus.alu_ovf;
            end else begin
                r_c <= r_c;
                r_v <= r_v;
            end
        end else begin
            r_res <= r_res;
            r_z   <= r_z;
            r_n   <= r_n;
            r_c   <= r_c;
            r_v   <= r_v;
        end
    end

`ifdef BFU_OVF_TRAP_EN
    logic r_trap;
    logic r_redirect;
    logic w_trap_set;

    assign w_trap_set = bus.alu_valid & bus.alu_update_carry & bus.alu_ovf;

    // Sticky trap: a new overflow outranks both trap_ack and the clear after a redirected RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_trap     <= 1'b0;
            r_redirect <= 1'b0;
        end else begin
            if (w_trap_set) begin
                r_trap <= 1'b1;
            end else if (bus.trap_ack || (w_retire && r_redirect)) begin
                r_trap <= 1'b0;
            end else begin
                r_trap <= r_trap;
            end
            if (w_resolve) begin
                r_redirect <= r_trap;
            end else if (w_retire) begin
                r_redirect <= 1'b0;
            end else begin
                r_redirect <= r_redirect;
            end
        end
    end

    assign w_redirect = r_trap;
    assign bus.trap   = r_trap;
`else
    logic w_unused_trap_ack;

    assign w_unused_trap_ack = bus.trap_ack;
    assign w_redirect        = 1'b0;
    assign bus.trap          = 1'b0;
`endif

    // Branch resolution from flags as they stand during EVAL
    always_comb begin
        w_cond = cond_met(r_type, r_c, r_z, r_n);
        w_take = 1'b0;
        w_pc   = r_pc4;
        w_link = 1'b0;
        if (w_redirect) begin
            w_take = 1'b1;
            w_pc   = TRAP_VECTOR;
            w_link = 1'b0;
        end else begin
            w_take = w_cond;
            w_pc   = w_cond ? r_target : r_pc4;
            w_link = (r_type == BT_BAL);
        end
    end

    // Registered response; take/next_pc/link_addr only change when a branch resolves
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_br_ready   <= 1'b1;
            r_pc_valid   <= 1'b0;
            r_link_valid <= 1'b0;
            r_take       <= 1'b0;
            r_next_pc    <= 32'h0000_0000;
            r_link_addr  <= 32'h0000_0000;
        end else begin
            r_br_ready   <= (w_next_state == ST_IDLE);
            r_pc_valid   <= w_resolve;
            r_link_valid <= w_resolve & w_link;
            if (w_resolve) begin
                r_take    <= w_take;
                r_next_pc <= w_pc;
                if (w_link) begin
                    r_link_addr <= r_pc4;
                end else begin
                    r_link_addr <= r_link_addr;
                end
            end else begin
                r_take      <= r_take;
                r_next_pc   <= r_next_pc;
                r_link_addr <= r_link_addr;
            end
        end
    end

    assign bus.br_ready   = r_br_ready;
    assign bus.pc_valid   = r_pc_valid;
    assign bus.take       = r_take;
    assign bus.next_pc    = r_next_pc;
    assign bus.link_valid = r_link_valid;
    assign bus.link_addr  = r_link_addr;
    assign bus.flags      = {r_c, r_z, r_n, r_v};
    assign bus.res_q      = r_res;
endmodule
